// File: rtl/fifo_write_arbiter_if.sv
// Requester-side valid/ready bundle plus the async_fifo write port shared by fifo_write_arbiter.
// master: the arbiter; slave: the requesters and FIFO that surround it.
interface fifo_write_arbiter_if #(
  parameter int BITS = 32,
  parameter int N    = 4
);
  logic [N-1:0]         req_valid;
  logic [N*BITS-1:0]    req_data;
  logic [N-1:0]         req_ready;
  logic                 p_write_full;
  logic                 p_write_en;
  logic [BITS-1:0]      p_write_data;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;

  modport master (
    input  req_valid, req_data, p_write_full,
    output req_ready, p_write_en, p_write_data, owner, busy
  );

  modport slave (
    output req_valid, req_data, p_write_full,
    input  req_ready, p_write_en, p_write_data, owner, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one async_fifo write port among N
// valid/ready requesters; runs in the FIFO write_clk domain.
module fifo_write_arbiter #(
  parameter int BITS      = 32,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  fifo_write_arbiter_if.master bus
);
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] pick, cand;
  logic          found;
  logic          owner_valid, accept;

  // Search starts one past the last grant and wraps mod N, so any N works.
  always_comb begin
    pick  = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = OW'((32'(rr_q) + i) % N);
      if (!found && bus.req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign owner_valid = bus.req_valid[owner_q];
  assign accept      = (state_q == BURST) && owner_valid && !bus.p_write_full;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_d             = rr_q;
    cnt_d            = cnt_q;
    bus.req_ready    = '0;
    bus.p_write_en   = 1'b0;
    bus.p_write_data = bus.req_data[owner_q*BITS +: BITS];
    bus.owner        = owner_q;
    bus.busy         = (state_q == BURST);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          owner_d = pick;
          rr_d    = pick;
          cnt_d   = '0;
        end
      end
      BURST: begin
        bus.req_ready[owner_q] = !bus.p_write_full;
        bus.p_write_en         = accept;
        if (accept) cnt_d = cnt_q + 1'b1;
        // A full stall with the owner still valid keeps the grant.
        if (!owner_valid || (accept && cnt_q == CW'(MAX_BURST - 1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OW'(N - 1);
      rr_q    <= OW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector table, then requester queues
// feeding a write-order scoreboard.
module tb_fifo_write_arbiter;
  localparam int BITS = 32;
  localparam int N    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.BITS(BITS), .N(N)) bus ();

  fifo_write_arbiter #(.BITS(BITS), .N(N), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] valid;
    logic       full;
    logic       chk;
    logic       en;
    logic [3:0] ready;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs [25];

  int tests = 0;
  int fails = 0;

  logic [31:0] src [N][$];
  logic [31:0] exp_q [$];
  logic [31:0] en_log;
  int          chk_owner;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  // One clock: drive requesters from their queues, sample before the edge, score writes.
  task automatic sb_cycle(input logic full, input logic r);
    logic [N-1:0] rdy, vld;
    rst = r;
    bus.p_write_full = full;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (src[i].size() != 0);
      bus.req_data[i*BITS +: BITS] = (src[i].size() != 0) ? src[i][0] : '0;
    end
    #1;
    en_log = {en_log[30:0], bus.p_write_en};
    if (bus.p_write_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'h0, bus.p_write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("write_data", {32'h0, bus.p_write_data}, {32'h0, exp_q.pop_front()});
      end
      if (chk_owner >= 0) check("write_owner", 64'(bus.owner), 64'(chk_owner));
    end
    rdy = bus.req_ready;
    vld = bus.req_valid;
    for (int i = 0; i < N; i++) if (rdy[i] && vld[i]) void'(src[i].pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name, input bit rnd_full);
    int budget = 400;
    while (exp_q.size() != 0 && budget > 0) begin
      sb_cycle(rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b0);
      budget--;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) src[i].delete();
    sb_cycle(1'b0, 1'b0);
    sb_cycle(1'b0, 1'b0);
  endtask

  initial begin
    //          rst valid  full chk en ready busy owner
    vecs[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3};
    vecs[2]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3};
    vecs[3]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3};
    vecs[4]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
    vecs[5]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
    vecs[6]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
    vecs[8]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    for (int k = 11; k <= 15; k++)
      vecs[k] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1};
    vecs[16] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    vecs[17] = '{1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
    vecs[18] = '{1'b0, 4'h9, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1};
    vecs[19] = '{1'b0, 4'h9, 1'b0, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3};
    vecs[20] = '{1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, 2'd3};
    vecs[21] = '{1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3};
    vecs[22] = '{1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
    vecs[23] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, 2'd0};
    vecs[24] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0};

    chk_owner = -1;
    en_log    = '0;
    bus.p_write_full = 1'b0;
    bus.req_valid    = '0;
    for (int i = 0; i < N; i++) bus.req_data[i*BITS +: BITS] = 32'hC0DE_0000 + 32'(i);

    // Reset hold, first grant, full stall, early release
    for (int k = 0; k < 25; k++) begin
      rst              = vecs[k].rst;
      bus.req_valid    = vecs[k].valid;
      bus.p_write_full = vecs[k].full;
      #1;
      if (vecs[k].chk) begin
        check($sformatf("vec%0d_ctl", k),
              64'({bus.p_write_en, bus.req_ready, bus.busy, bus.owner}),
              64'({vecs[k].en, vecs[k].ready, vecs[k].busy, vecs[k].owner}));
        if (vecs[k].en)
          check($sformatf("vec%0d_data", k), 64'(bus.p_write_data),
                64'(32'hC0DE_0000 + 32'(vecs[k].owner)));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Single requester streaming 10 words: 4, bubble, 4, bubble, 2
    chk_owner = 2;
    en_log    = '0;
    for (int s = 0; s < 10; s++) begin
      src[2].push_back(32'hA0 + 32'(s));
      exp_q.push_back(32'hA0 + 32'(s));
    end
    for (int c = 0; c < 14; c++) sb_cycle(1'b0, 1'b0);
    check("single_pattern", 64'(en_log[13:0]), 64'(14'b01111011110110));
    check("single_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk_owner = -1;

    // All requesters, rotation from 0 after reset, with random full stalls
    sb_cycle(1'b0, 1'b1);
    for (int i = 0; i < N; i++)
      for (int s = 0; s < 8; s++) src[i].push_back(32'(i << 8) | 32'(s));
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        for (int s = 0; s < 4; s++) exp_q.push_back(32'(i << 8) | 32'(b * 4 + s));
    drain("all_req", 1'b1);

    // Reset in the second cycle of requester 1's burst
    for (int s = 0; s < 4; s++) src[1].push_back(32'h6000 + 32'(s));
    exp_q.push_back(32'h6000);
    exp_q.push_back(32'h6001);
    sb_cycle(1'b0, 1'b0);
    sb_cycle(1'b0, 1'b0);
    sb_cycle(1'b0, 1'b1);
    check("rst_burst_written", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    src[0].push_back(32'h5000);
    bus.req_valid[0] = 1'b1;
    bus.req_data[0 +: BITS] = 32'h5000;
    #1;
    check("post_rst_ctl", 64'({bus.p_write_en, bus.busy, bus.owner}), 64'({1'b0, 1'b0, 2'd3}));
    exp_q.push_back(32'h5000);
    exp_q.push_back(32'h6002);
    exp_q.push_back(32'h6003);
    drain("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
